// File: rtl/sub_256_seq.sv
// Sequential 256-bit subtractor: diff = a - b - B_EN, one CHUNK_W slice per clock, LSB first.
// Optional macro SUB256_UNDERFLOW_SAT_EN clamps diff to zero when the final borrow is set.
module sub_256_seq #(
    parameter int CHUNK_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] a,
    input  logic [255:0] b,
    input  logic         B_EN,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] diff,
    output logic         borrow_out
);
    localparam int NCHUNK = 256 / CHUNK_W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic           borrow;
    logic [255:0]   a_sh;
    logic [255:0]   b_sh;
    logic [CHUNK_W:0] slice;

    // Operands shift right each RUN cycle so the active slice is always the low CHUNK_W bits.
    // The extra top bit of the widened subtraction is the slice borrow-out.
    always_comb begin
        slice = {1'b0, a_sh[CHUNK_W-1:0]} - {1'b0, b_sh[CHUNK_W-1:0]}
              - {{CHUNK_W{1'b0}}, borrow};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            borrow     <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh       <= a;
                        b_sh       <= b;
                        borrow     <= B_EN;
                        k          <= '0;
                        diff       <= '0;
                        borrow_out <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    diff[k*CHUNK_W +: CHUNK_W] <= slice[CHUNK_W-1:0];
                    borrow <= slice[CHUNK_W];
                    a_sh   <= a_sh >> CHUNK_W;
                    b_sh   <= b_sh >> CHUNK_W;
                    k      <= k + 1'b1;
                    if (k == KW'(NCHUNK - 1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        borrow_out <= slice[CHUNK_W];
`ifdef SUB256_UNDERFLOW_SAT_EN
                        // Later assignment overrides the slice write above.
                        if (slice[CHUNK_W]) diff <= '0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sub_256_seq.md
SUB_256_SEQ -- requirements
Module: sub_256_seq

Interface
REQ-001 The block SHALL have parameter CHUNK_W, default 32, giving the per-cycle subtract slice width; legal values are 8, 16, 32, 64 and 128.
REQ-002 The block SHALL define NCHUNK = 256/CHUNK_W as the number of RUN cycles per operation (8 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, 256 bits: minuend.
REQ-008 The block SHALL have port b, input, 256 bits: subtrahend.
REQ-009 The block SHALL have port B_EN, input, 1 bit: borrow-in enable, sampled at accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream takes result.
REQ-012 The block SHALL have port diff, output, 256 bits: a - b - B_EN, modulo 2^256.
REQ-013 The block SHALL have port borrow_out, output, 1 bit: final borrow, 1 when a < b + B_EN.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; it SHALL be 0 in RUN and DONE.
REQ-016 Accept SHALL be in_valid && in_ready at a clock edge: capture a, b and B_EN, set borrow register = B_EN and chunk index k = 0, then go to RUN.
REQ-017 Each RUN cycle SHALL compute diff[k*CHUNK_W +: CHUNK_W] = a_k - b_k - borrow, update borrow with that slice's borrow-out, and increment k (LSB slice first).
REQ-018 After slice NCHUNK-1 the FSM SHALL go to DONE; out_valid SHALL be 1 from the edge that is NCHUNK edges after the accept edge (8 at default).
REQ-019 In DONE, diff and borrow_out SHALL be held stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-020 Changes on a, b, B_EN or in_valid while in RUN or DONE SHALL be ignored, and no operation SHALL be lost or duplicated.
REQ-021 out_ready SHALL have no effect outside DONE.
REQ-022 Back-to-back operation: an accept SHALL be possible on the cycle after the DONE handshake, giving a throughput of one result per NCHUNK+2 cycles.
REQ-023 diff bits not yet written in RUN SHALL read 0; diff SHALL be cleared at each accept.

Reset
REQ-024 Reset assertion SHALL immediately, without clk, force the FSM to IDLE, k=0, borrow=0, diff=0, borrow_out=0 and out_valid=0.
REQ-025 During reset, in_ready SHALL be 1 only after reset deasserts: it SHALL be 0 while rst=0 and 1 from the first edge in IDLE.
REQ-026 Reset in RUN or DONE SHALL abort the operation; no partial result SHALL appear after release.

Configuration
REQ-027 Macro SUB256_UNDERFLOW_SAT_EN SHALL control underflow saturation.
REQ-028 When SUB256_UNDERFLOW_SAT_EN is defined and the final borrow is 1, diff SHALL be forced to all zeros on entry to DONE; borrow_out SHALL still be 1.
REQ-029 When SUB256_UNDERFLOW_SAT_EN is undefined, diff SHALL be the modulo 2^256 result and no saturation logic SHALL be present.

Verification
REQ-030 Basic subtract: a=5, b=3, B_EN=0, out_ready=1 -> diff=2, borrow_out=0, out_valid rises 8 edges after accept.
REQ-031 Cross-slice borrow: a=2^32, b=1, B_EN=0 -> diff=0x...0000_FFFFFFFF with upper 224 bits 0, borrow_out=0.
REQ-032 Underflow: a=0, b=1 -> borrow_out=1; without the macro diff = all ones; with SUB256_UNDERFLOW_SAT_EN diff = 0.
REQ-033 Borrow-in and backpressure: a=5, b=3, B_EN=1, out_ready=0 for 5 cycles after out_valid -> diff=1 held stable and in_ready=0 throughout; a new in_valid pulse in that window is not accepted.
REQ-034 Reset mid-RUN: rst=0 at RUN cycle 4 -> out_valid=0 and diff=0 immediately; after release in_ready=1 and the next operation a=10, b=4 gives diff=6.
